// File: rtl/ram_large_ctrl_pkg.sv
// Shared constants and FSM state encoding for the large-RAM request/response controller.
// Default widths match the 4-bank 32K x 16 RAM instance.
package ram_large_ctrl_pkg;

  localparam int unsigned RAM_ADDR_WIDTH = 15;
  localparam int unsigned RAM_DATA_WIDTH = 16;
  localparam int unsigned STATE_WIDTH    = 3;
  localparam int unsigned WAIT_CNT_WIDTH = 2;
  localparam int unsigned RD_WAIT_MAX    = 3;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_RD_ADDR  = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RD_DATA  = 3'd4,
    ST_RSP_WAIT = 3'd5
  } ctrl_state_e;

endpackage

// File: rtl/ram_large_ctrl_if.sv
// Request/response stream bundle between a CPU-side master and the RAM controller.
interface ram_large_ctrl_if
  import ram_large_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = RAM_DATA_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/ram_large_ctrl.sv
// Valid/ready front-end for the single-port 32K x 16 sync RAM: one request in flight,
// owns the tri-state data bus, returns read data on a buffered response port.
module ram_large_ctrl
  import ram_large_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int unsigned RD_WAIT    = 0
)(
  input  logic                  clk,
  input  logic                  rst_n,
  ram_large_ctrl_if.slave       bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic                  busy
);

  ctrl_state_e               state;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic                      drive_en;
  logic [WAIT_CNT_WIDTH-1:0] wait_cnt;

  // Bus is only ever driven during the single WRITE cycle, when mem_oe is low.
  assign mem_data = drive_en ? wdata_q : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      wdata_q       <= '0;
      drive_en      <= 1'b0;
      wait_cnt      <= '0;
      mem_addr      <= '0;
      mem_cs        <= 1'b0;
      mem_we        <= 1'b0;
      mem_oe        <= 1'b0;
      busy          <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            mem_addr      <= bus.req_addr;
            wdata_q       <= bus.req_wdata;
            mem_cs        <= 1'b1;
            busy          <= 1'b1;
            bus.req_ready <= 1'b0;
            if (bus.req_we) begin
              state    <= ST_WRITE;
              mem_we   <= 1'b1;
              mem_oe   <= 1'b0;
              drive_en <= 1'b1;
            end else begin
              state    <= ST_RD_ADDR;
              mem_we   <= 1'b0;
              mem_oe   <= 1'b1;
              drive_en <= 1'b0;
            end
          end
        end

        ST_WRITE: begin
          state         <= ST_IDLE;
          mem_cs        <= 1'b0;
          mem_we        <= 1'b0;
          drive_en      <= 1'b0;
          busy          <= 1'b0;
          bus.req_ready <= 1'b1;
        end

        // RAM registers mem[addr] at the end of this cycle; pins stay put until sampled.
        ST_RD_ADDR: begin
          if (RD_WAIT != 0) begin
            state    <= ST_RD_WAIT;
            wait_cnt <= WAIT_CNT_WIDTH'(RD_WAIT - 1);
          end else begin
            state    <= ST_RD_DATA;
          end
        end

        ST_RD_WAIT: begin
          if (wait_cnt == '0) begin
            state <= ST_RD_DATA;
          end else begin
            wait_cnt <= wait_cnt - WAIT_CNT_WIDTH'(1);
          end
        end

        ST_RD_DATA: begin
          state         <= ST_RSP_WAIT;
          bus.rsp_rdata <= mem_data;
          bus.rsp_valid <= 1'b1;
          mem_cs        <= 1'b0;
          mem_oe        <= 1'b0;
        end

        // Response buffer holds until the consumer takes it.
        ST_RSP_WAIT: begin
          if (bus.rsp_ready) begin
            state         <= ST_IDLE;
            bus.rsp_valid <= 1'b0;
            busy          <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end

        default: begin
          state         <= ST_IDLE;
          mem_cs        <= 1'b0;
          mem_we        <= 1'b0;
          mem_oe        <= 1'b0;
          drive_en      <= 1'b0;
          busy          <= 1'b0;
          bus.rsp_valid <= 1'b0;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_large_ctrl.sv
// Directed bench for ram_large_ctrl: two controllers (RD_WAIT=0 and RD_WAIT=2), each
// talking to a behavioural model of the single-port 32K x 16 sync RAM.
module tb_ram_large_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_large_ctrl_if if0 ();
  ram_large_ctrl_if if1 ();

  wire  [15:0] mem_data0, mem_data1;
  logic [14:0] mem_addr0, mem_addr1;
  logic mem_cs0, mem_we0, mem_oe0, busy0;
  logic mem_cs1, mem_we1, mem_oe1, busy1;

  ram_large_ctrl #(.RD_WAIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave),
    .mem_addr(mem_addr0), .mem_data(mem_data0),
    .mem_cs(mem_cs0), .mem_we(mem_we0), .mem_oe(mem_oe0), .busy(busy0)
  );

  ram_large_ctrl #(.RD_WAIT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave),
    .mem_addr(mem_addr1), .mem_data(mem_data1),
    .mem_cs(mem_cs1), .mem_we(mem_we1), .mem_oe(mem_oe1), .busy(busy1)
  );

  // RAM models: write on cs&we, register read on cs&oe&!we, drive bus the following cycle.
  logic [15:0] ram0 [0:32767];
  logic [15:0] ram1 [0:32767];
  logic [15:0] rd_q0, rd_q1;
  logic rd_en0 = 1'b0;
  logic rd_en1 = 1'b0;

  always @(posedge clk) begin
    if (mem_cs0 && mem_we0) ram0[mem_addr0] <= mem_data0;
    if (mem_cs0 && mem_oe0 && !mem_we0) rd_q0 <= ram0[mem_addr0];
    rd_en0 <= rst_n && mem_cs0 && mem_oe0 && !mem_we0;
    if (mem_cs1 && mem_we1) ram1[mem_addr1] <= mem_data1;
    if (mem_cs1 && mem_oe1 && !mem_we1) rd_q1 <= ram1[mem_addr1];
    rd_en1 <= rst_n && mem_cs1 && mem_oe1 && !mem_we1;
  end

  assign mem_data0 = (rd_en0 && mem_oe0 && !mem_we0) ? rd_q0 : 16'hzzzz;
  assign mem_data1 = (rd_en1 && mem_oe1 && !mem_we1) ? rd_q1 : 16'hzzzz;

  // Contention shows up as X on the resolved bus.
  logic x_seen0 = 1'b0;
  logic x_seen1 = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 16; i++) begin
        if (mem_data0[i] === 1'bx) x_seen0 <= 1'b1;
        if (mem_data1[i] === 1'bx) x_seen1 <= 1'b1;
      end
    end
  end

  int cyc = 0;
  int rsp_cnt0 = 0;
  logic [15:0] rsp_last0 = 16'h0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (if0.rsp_valid && if0.rsp_ready) begin
      rsp_cnt0  <= rsp_cnt0 + 1;
      rsp_last0 <= if0.rsp_rdata;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int sel, input logic v, input logic we,
                         input logic [14:0] a, input logic [15:0] d);
    if (sel == 0) begin
      if0.req_valid = v; if0.req_we = we; if0.req_addr = a; if0.req_wdata = d;
    end else begin
      if1.req_valid = v; if1.req_we = we; if1.req_addr = a; if1.req_wdata = d;
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? if0.req_ready : if1.req_ready;
  endfunction

  function automatic logic rvalid(input int sel);
    return (sel == 0) ? if0.rsp_valid : if1.rsp_valid;
  endfunction

  function automatic logic [15:0] rdata(input int sel);
    return (sel == 0) ? if0.rsp_rdata : if1.rsp_rdata;
  endfunction

  task automatic wait_ready(input int sel, input string tag);
    int n = 0;
    while (!rdy(sel) && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, 32'(rdy(sel)), 32'd1);
  endtask

  task automatic do_write(input int sel, input logic [14:0] a, input logic [15:0] d,
                          input string tag);
    wait_ready(sel, tag);
    set_req(sel, 1'b1, 1'b1, a, d);
    tick();
    set_req(sel, 1'b0, 1'b0, a, d);
    check({tag, "_bus"},  32'((sel == 0) ? mem_data0 : mem_data1), 32'(d));
    check({tag, "_weoe"}, 32'((sel == 0) ? {mem_we0, mem_oe0} : {mem_we1, mem_oe1}), 32'b10);
    tick();
  endtask

  task automatic do_read(input int sel, input logic [14:0] a, input logic [15:0] exp,
                         input int lat, input string tag);
    int n = 0;
    wait_ready(sel, tag);
    set_req(sel, 1'b1, 1'b0, a, 16'h0);
    tick();
    set_req(sel, 1'b0, 1'b0, a, 16'h0);
    while (!rvalid(sel) && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_lat"},   32'(n), 32'(lat));
    check({tag, "_rdata"}, 32'(rdata(sel)), 32'(exp));
    tick();
    check({tag, "_taken"}, 32'(rvalid(sel)), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [14:0] bank_addr [4];
  logic [15:0] bank_data [4];
  logic        b2b_we    [3];
  logic [15:0] b2b_data  [3];
  int          acc       [3];
  int          base;

  initial begin
    bank_addr[0] = 15'h0000; bank_data[0] = 16'h1111;
    bank_addr[1] = 15'h2000; bank_data[1] = 16'h2222;
    bank_addr[2] = 15'h4000; bank_data[2] = 16'h3333;
    bank_addr[3] = 15'h7FFF; bank_data[3] = 16'h4444;
    b2b_we[0] = 1'b1; b2b_data[0] = 16'hA5A5;
    b2b_we[1] = 1'b0; b2b_data[1] = 16'h0000;
    b2b_we[2] = 1'b1; b2b_data[2] = 16'h5A5A;

    set_req(0, 1'b0, 1'b0, 15'h0, 16'h0);
    set_req(1, 1'b0, 1'b0, 15'h0, 16'h0);
    if0.rsp_ready = 1'b1;
    if1.rsp_ready = 1'b1;

    // Power-on reset
    repeat (3) tick();
    check("por_req_ready", 32'(if0.req_ready), 32'd1);
    check("por_pins", 32'({mem_cs0, mem_we0, mem_oe0, busy0}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Write 0x0003 then read it back with two-cycle latency
    do_write(0, 15'h0003, 16'hBEEF, "t2_wr");
    do_read(0, 15'h0003, 16'hBEEF, 2, "t2_rd");

    // Reset asserted mid-read clears everything asynchronously and no response follows
    set_req(0, 1'b1, 1'b0, 15'h0003, 16'h0);
    tick();
    set_req(0, 1'b0, 1'b0, 15'h0, 16'h0);
    check("t1_rdaddr_pins", 32'({mem_cs0, mem_we0, mem_oe0, busy0}), 32'b1011);
    #2 rst_n = 1'b0;
    #1;
    check("t1_req_ready", 32'(if0.req_ready), 32'd1);
    check("t1_rsp_valid", 32'(if0.rsp_valid), 32'd0);
    check("t1_rsp_rdata", 32'(if0.rsp_rdata), 32'd0);
    check("t1_pins", 32'({mem_cs0, mem_we0, mem_oe0, busy0}), 32'd0);
    check("t1_addr", 32'(mem_addr0), 32'd0);
    check("t1_bus_released", 32'(dut0.drive_en), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    base = rsp_cnt0;
    repeat (6) tick();
    check("t1_no_rsp", 32'(rsp_cnt0 - base), 32'd0);
    check("t1_idle", 32'({if0.req_ready, busy0}), 32'b10);

    // Bank crossing writes and reads
    for (int i = 0; i < 4; i++) do_write(0, bank_addr[i], bank_data[i], $sformatf("t3_wr%0d", i));
    for (int i = 0; i < 4; i++) do_read(0, bank_addr[i], bank_data[i], 2, $sformatf("t3_rd%0d", i));
    check("t3_addr_hold", 32'(mem_addr0), 32'h7FFF);

    // Backpressure: response held stable and no new accept while rsp_ready is low
    if0.rsp_ready = 1'b0;
    wait_ready(0, "t4");
    set_req(0, 1'b1, 1'b0, 15'h2000, 16'h0);
    tick();
    set_req(0, 1'b0, 1'b0, 15'h0, 16'h0);
    repeat (2) tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t4_hold%0d", i),
            32'({if0.rsp_valid, if0.req_ready, if0.rsp_rdata}), 32'({1'b1, 1'b0, 16'h2222}));
      tick();
    end
    if0.rsp_ready = 1'b1;
    tick();
    check("t4_release", 32'({if0.rsp_valid, if0.req_ready}), 32'b01);

    // Back-to-back with req_valid held high: write, read, write
    base = rsp_cnt0;
    for (int i = 0; i < 3; i++) begin
      int n = 0;
      set_req(0, 1'b1, b2b_we[i], 15'h0100, b2b_data[i]);
      while (!if0.req_ready && n < 20) begin
        tick();
        n++;
      end
      check($sformatf("t5_ready%0d", i), 32'(if0.req_ready), 32'd1);
      tick();
      acc[i] = cyc;
    end
    set_req(0, 1'b0, 1'b0, 15'h0, 16'h0);
    tick();
    check("t5_gap_wr_rd", 32'(acc[1] - acc[0]), 32'd2);
    check("t5_gap_rd_wr", 32'(acc[2] - acc[1]), 32'd4);
    check("t5_rsp_count", 32'(rsp_cnt0 - base), 32'd1);
    check("t5_rsp_order", 32'(rsp_last0), 32'hA5A5);
    do_read(0, 15'h0100, 16'h5A5A, 2, "t5_final");

    // RD_WAIT=2 instance: four-cycle read latency, clean bus throughout
    do_write(1, 15'h1234, 16'hCAFE, "t6_wr");
    do_read(1, 15'h1234, 16'hCAFE, 4, "t6_rd");
    check("t6_no_x_bus1", 32'(x_seen1), 32'd0);
    check("t6_no_x_bus0", 32'(x_seen0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
